// File: rtl/da_shift_accumulator.sv
// Bit-serial distributed-arithmetic shift-accumulator for one 8-point DCT
// coefficient. Consumes one ROM partial sum per cycle, LSB first, weights it
// by the current bit position and subtracts the sign-bit term. It also drives
// the ROM chip-select and the bit index used by the sample serializer.
module da_shift_accumulator #(
  parameter int DATA_W = 16,
  parameter int ROM_W  = 16,
  parameter int ACC_W  = ROM_W + DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ROM_W:0]            rom_data,
  output logic                      rom_cs,
  output logic [$clog2(DATA_W)-1:0] bit_idx,
  output logic                      busy,
  output logic                      valid,
  output logic [ACC_W-1:0]          z_out
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] acc_sub;
  logic             last_bit;
  logic             start_accept;
  logic             unused_rom_flag;

  // The ROM's top bit carries no value information and is deliberately dropped.
  assign unused_rom_flag = rom_data[ROM_W];

  // Sign-extend the partial sum to full precision, then weight it by 2^bit_idx.
  // The combinational ROM already reflects the current bit_idx on this edge.
  assign term     = {{(ACC_W - ROM_W){rom_data[ROM_W-1]}}, rom_data[ROM_W-1:0]} << bit_idx;
  assign acc_add  = acc + term;
  assign acc_sub  = acc - term;
  assign last_bit = (bit_idx == LAST_IDX);

  // start is honoured only when no coefficient is in flight.
  assign start_accept = start && ((state == IDLE) || (state == DONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: run DATA_W accumulate cycles, then one DONE cycle that
  // may chain straight into the next coefficient.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_accept) state_next = ACCUM;
      ACCUM:   if (last_bit) state_next = DONE;
      DONE:    state_next = start_accept ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs: accumulate, subtract the sign-bit term,
  // publish the result with a one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      bit_idx <= '0;
      rom_cs  <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      z_out   <= '0;
    end else begin
      valid  <= 1'b0;
      rom_cs <= (state_next == ACCUM);
      busy   <= (state_next == ACCUM);
      if (state == ACCUM) begin
        if (last_bit) begin
          acc     <= acc_sub;
          z_out   <= acc_sub;
          valid   <= 1'b1;
          bit_idx <= '0;
        end else begin
          acc     <= acc_add;
          bit_idx <= bit_idx + IDX_W'(1);
        end
      end else if (start_accept) begin
        acc     <= '0;
        bit_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Self-checking bench for da_shift_accumulator. A table-driven ROM model feeds
// rom_data from bit_idx; expected coefficients go into a scoreboard queue when
// a job is launched and are popped when valid is seen.
module tb_da_shift_accumulator;

  localparam int DATA_W = 16;
  localparam int ROM_W  = 16;
  localparam int ACC_W  = 32;

  typedef struct {
    logic [15:0] v;
    int          sel;
    logic [31:0] z;
  } job_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ROM_W:0]    rom_data;
  logic              rom_cs;
  logic [3:0]        bit_idx;
  logic              busy;
  logic              valid;
  logic [ACC_W-1:0]  z_out;

  logic [ROM_W-1:0]  rom_tab [DATA_W];
  logic              junk_bit = 1'b0;
  logic [ACC_W-1:0]  exp_q [$];
  int                n_checks = 0;
  int                n_pass = 0;

  da_shift_accumulator #(
    .DATA_W(DATA_W),
    .ROM_W (ROM_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rom_data(rom_data),
    .rom_cs  (rom_cs),
    .bit_idx (bit_idx),
    .busy    (busy),
    .valid   (valid),
    .z_out   (z_out)
  );

  always #5 clk = ~clk;

  // Combinational coefficient ROM model with a junk top bit the DUT must ignore.
  assign rom_data = {junk_bit, rom_tab[bit_idx]};

  // Load the ROM table: value v at position sel, or at every position if sel < 0.
  task automatic fill_table(input logic [15:0] v, input int sel);
    for (int k = 0; k < DATA_W; k++)
      rom_tab[k] = ((sel < 0) || (sel == k)) ? v : 16'h0000;
    junk_bit = 1'($urandom_range(0, 1));
  endtask

  // Reference coefficient for the current ROM table.
  function automatic logic [31:0] model_z();
    logic signed [31:0] a;
    logic signed [31:0] t;
    a = 0;
    for (int k = 0; k < DATA_W; k++) begin
      t = {{16{rom_tab[k][15]}}, rom_tab[k]};
      t = t <<< k;
      if (k == DATA_W - 1) a = a - t;
      else a = a + t;
    end
    return a;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    fill_table(16'h0000, -1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (rom_cs !== 1'b0) $display("[TB] FAIL reset_rom_cs: got %b expected 0", rom_cs);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid);
    else n_pass++;
    n_checks++;
    if (bit_idx !== 4'd0) $display("[TB] FAIL reset_bit_idx: got %0d expected 0", bit_idx);
    else n_pass++;
    n_checks++;
    if (z_out !== 32'h0) $display("[TB] FAIL reset_z_out: got %h expected 00000000", z_out);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_jobs();
    job_t jobs [4];
    jobs = '{'{16'h4000, -1, 32'hFFFFC000},
             '{16'h4000,  0, 32'h00004000},
             '{16'h4000, 15, 32'hE0000000},
             '{16'hADFC,  3, 32'hFFFD6FE0}};
    for (int j = 0; j < 4; j++) begin
      int cycles;
      int bad_seq;
      logic seen;
      logic [31:0] exp_z;
      fill_table(jobs[j].v, jobs[j].sel);
      exp_q.push_back(jobs[j].z);
      start = 1'b1;
      cycles = 0;
      bad_seq = 0;
      seen = 1'b0;
      while (!seen && cycles < 40) begin
        @(negedge clk);
        cycles++;
        start = 1'b0;
        if (valid) seen = 1'b1;
        else if (cycles <= DATA_W &&
                 (busy !== 1'b1 || rom_cs !== 1'b1 || bit_idx !== 4'(cycles - 1)))
          bad_seq++;
      end
      n_checks++;
      if (!seen || cycles != 17)
        $display("[TB] FAIL single%0d_latency: got %0d cycles (seen=%b) expected 17", j, cycles, seen);
      else n_pass++;
      n_checks++;
      if (bad_seq != 0)
        $display("[TB] FAIL single%0d_accum_seq: got %0d bad cycles expected 0", j, bad_seq);
      else n_pass++;
      exp_z = exp_q.pop_front();
      n_checks++;
      if (z_out !== exp_z) $display("[TB] FAIL single%0d_z_out: got %h expected %h", j, z_out, exp_z);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({valid, busy, rom_cs, bit_idx} !== 7'd0)
        $display("[TB] FAIL single%0d_idle_after: got valid=%b busy=%b rom_cs=%b bit_idx=%0d expected all 0",
                 j, valid, busy, rom_cs, bit_idx);
      else n_pass++;
      n_checks++;
      if (z_out !== exp_z) $display("[TB] FAIL single%0d_z_hold: got %h expected %h", j, z_out, exp_z);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 3; j++) begin
      int cycles;
      logic seen;
      logic [31:0] exp_z;
      for (int k = 0; k < DATA_W; k++) rom_tab[k] = 16'($urandom);
      junk_bit = 1'($urandom_range(0, 1));
      exp_q.push_back(model_z());
      start = 1'b1;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < 40) begin
        @(negedge clk);
        cycles++;
        start = 1'b0;
        if (valid) seen = 1'b1;
      end
      n_checks++;
      if (!seen || cycles != 17)
        $display("[TB] FAIL random%0d_latency: got %0d cycles (seen=%b) expected 17", j, cycles, seen);
      else n_pass++;
      exp_z = exp_q.pop_front();
      n_checks++;
      if (z_out !== exp_z) $display("[TB] FAIL random%0d_z_out: got %h expected %h", j, z_out, exp_z);
      else n_pass++;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int cycles;
    int spurious;
    logic seen;
    logic [31:0] exp_z;
    fill_table(16'h4000, -1);
    start = 1'b1;
    cycles = 0;
    spurious = 0;
    do begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (valid) spurious++;
    end while (bit_idx != 4'd7 && cycles < 40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (valid) spurious++;
    n_checks++;
    if (bit_idx !== 4'd8 || busy !== 1'b1)
      $display("[TB] FAIL abort_start_ignored: got bit_idx=%0d busy=%b expected 8/1", bit_idx, busy);
    else n_pass++;
    cycles = 0;
    while (bit_idx != 4'd10 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (valid) spurious++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid, busy, rom_cs, bit_idx} !== 7'd0 || z_out !== 32'h0)
      $display("[TB] FAIL abort_reset_outputs: got valid=%b busy=%b rom_cs=%b bit_idx=%0d z_out=%h expected all 0",
               valid, busy, rom_cs, bit_idx, z_out);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      if (valid) spurious++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (valid) spurious++;
    end
    n_checks++;
    if (spurious != 0) $display("[TB] FAIL abort_no_valid: got %0d valid pulses expected 0", spurious);
    else n_pass++;
    fill_table(16'h4000, -1);
    exp_q.push_back(32'hFFFFC000);
    start = 1'b1;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cycles != 17)
      $display("[TB] FAIL abort_recover_latency: got %0d cycles (seen=%b) expected 17", cycles, seen);
    else n_pass++;
    exp_z = exp_q.pop_front();
    n_checks++;
    if (z_out !== exp_z) $display("[TB] FAIL abort_recover_z_out: got %h expected %h", z_out, exp_z);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cycles;
    int since;
    int done_jobs;
    int bad_busy;
    logic [31:0] exp_z;
    fill_table(16'h4000, -1);
    exp_q.push_back(32'hFFFFC000);
    start = 1'b1;
    cycles = 0;
    since = 0;
    done_jobs = 0;
    bad_busy = 0;
    while (done_jobs < 4 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      since++;
      if (busy !== !valid) bad_busy++;
      if (valid) begin
        n_checks++;
        if (since != 17)
          $display("[TB] FAIL b2b%0d_interval: got %0d cycles expected 17", done_jobs, since);
        else n_pass++;
        exp_z = exp_q.pop_front();
        n_checks++;
        if (z_out !== exp_z) $display("[TB] FAIL b2b%0d_z_out: got %h expected %h", done_jobs, z_out, exp_z);
        else n_pass++;
        since = 0;
        done_jobs++;
        if (done_jobs < 4) begin
          if (done_jobs % 2 == 1) begin
            fill_table(16'h0000, -1);
            exp_q.push_back(32'h00000000);
          end else begin
            fill_table(16'h4000, -1);
            exp_q.push_back(32'hFFFFC000);
          end
        end else begin
          start = 1'b0;
        end
      end
    end
    n_checks++;
    if (done_jobs != 4) $display("[TB] FAIL b2b_job_count: got %0d expected 4", done_jobs);
    else n_pass++;
    n_checks++;
    if (bad_busy != 0) $display("[TB] FAIL b2b_busy_pattern: got %0d bad cycles expected 0", bad_busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({valid, busy} !== 2'b00)
      $display("[TB] FAIL b2b_idle_after: got valid=%b busy=%b expected 0/0", valid, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_jobs();
    test_random();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/da_shift_accumulator.md
# da_shift_accumulator

Bit-serial distributed-arithmetic (DA) shift-accumulator for one 8-point DCT output coefficient. It sits directly downstream of a per-coefficient DA coefficient ROM. Each cycle it takes that ROM's combinational partial-sum word and weights it by the current bit position. Bit positions run LSB-first over DATA_W cycles, and the sign-bit cycle is subtracted. It also drives the ROM chip-select and the bit index used by the upstream sample serializer.

## Interface
- DATA_W, 16: sample width and number of bit-serial cycles per coefficient.
- ROM_W, 16: width of the ROM partial sum, two's complement Q2.14.
- ACC_W, 32: accumulator/result width, equal to ROM_W + DATA_W; result is Q(ACC_W-14).14.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  one-cycle request to begin a coefficient; accepted only in IDLE or DONE.
- rom_data  input  ROM_W+1  ROM output; bits [ROM_W-1:0] are the two's-complement value; bit ROM_W is ignored.
- rom_cs  output  1  ROM chip select; high only in ACCUM.
- bit_idx  output  $clog2(DATA_W)  bit position the serializer must present this cycle (0 = LSB).
- busy  output  1  high in ACCUM.
- valid  output  1  one-cycle pulse: z_out updated.
- z_out  output  ACC_W  signed coefficient result, held until the next valid.

## Operation
- FSM states are IDLE, ACCUM and DONE.
  - IDLE: start=1 moves to ACCUM, clears acc, sets bit_idx=0.
  - ACCUM: on every rising edge, rom_data is sign-extended to ACC_W and shifted left by bit_idx.
    - For bit_idx < DATA_W-1: acc <= acc + term.
    - For bit_idx == DATA_W-1 (sign bit): acc <= acc - term, and the FSM moves to DONE.
    - Otherwise bit_idx increments.
  - DONE: z_out <= acc (final value), valid=1 for this cycle only.
    - start=1 here moves straight to ACCUM with acc cleared and bit_idx=0 (back-to-back).
    - Otherwise the FSM moves to IDLE.
- start in ACCUM is ignored; it is neither queued nor restarted.
- The ROM is combinational, so rom_data for address bits at bit_idx=k is consumed on the same edge that advances k.
- Arithmetic is full-precision two's complement with no saturation. ACC_W = ROM_W + DATA_W cannot overflow.
- The ROM returns 0 for one cycle after its own reset release. Upstream holds start low for ≥2 cycles after rst_n rises.

## Timing
- Reset (rst_n=0, asynchronous) sets:
  - state=IDLE, acc=0, bit_idx=0
  - rom_cs=0, busy=0, valid=0, z_out=0
- Reset mid-ACCUM aborts immediately. No valid is produced, and z_out is cleared to 0.
- Latency: start sampled at edge t gives ACCUM on cycles t+1..t+DATA_W, then valid=1 in cycle t+DATA_W+1 with z_out already updated.
- Throughput:
  - Back-to-back: one coefficient per DATA_W+1 cycles.
  - Otherwise: DATA_W+2 cycles per coefficient, including IDLE.
- rom_cs, busy and bit_idx are registered and change only on clock edges. bit_idx stays 0 outside ACCUM.
- valid is never high for two consecutive cycles.

## Test plan
- rom_data=16'h4000 held for all 16 bits, single start -> valid once after 17 cycles; z_out=32'hFFFFC000, i.e. (2^15-1-2^15)·1.0.
- rom_data=16'h4000 only while bit_idx=0, 0 otherwise -> z_out=32'h00004000.
- rom_data=16'h4000 only while bit_idx=15 -> z_out=32'hE0000000 (sign-bit subtraction).
- rom_data=16'hADFC only while bit_idx=3 -> z_out=32'hFFFD6FE0 (−20996·8).
- Second start pulsed at ACCUM bit_idx=7, then rst_n low at bit_idx=10 -> start ignored; all outputs 0, no valid. After release and a new start, a normal 17-cycle result is produced.
- start held high continuously with alternating constant rom_data 16'h4000 / 16'h0000 per job -> valid every 17 cycles; z_out alternates 32'hFFFFC000 / 32'h00000000; busy low only in DONE cycles.
